// File: rtl/alu_pkg.sv
// Shared ALU definitions: alucontrol codes from the ALU decoder and the
// sequencing states of the multi-cycle ALU.
package alu_pkg;

  // alucontrol codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_SLT = 4'b1011;
  localparam logic [3:0] ALU_LUI = 4'b1101;

  // Sequencer states of alu_mc
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2
  } alu_state_t;

endpackage

// File: rtl/mul_seq.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// start loads the operands; done is high during the cycle whose closing edge
// folds in the last multiplier bit, with product already showing the final
// low WIDTH bits, so the caller can register it on that same edge.
module mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_sum;

  // Partial-product accumulation for the current multiplier bit
  always_comb begin
    acc_sum = acc + (mplier[0] ? mcand : '0);
    product = acc_sum;
    done    = running && (cnt == CW'(1));
  end

  // Operand load on start, then one shift-add step per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= CW'(WIDTH);
      acc     <= '0;
      mcand   <= a;
      mplier  <= b;
    end else if (running) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops, a one-bit-per-cycle
// left shifter and a sequential multiplier. Results are registered and held
// until the next done pulse.
//
//   state | meaning
//   IDLE  | ready; start accepted, single-cycle ops complete here
//   SHIFT | shifting sll operand left one bit per cycle
//   MUL   | waiting on mul_seq to finish the product
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  alu_state_t       state, state_next;
  logic [4:0]       sh_cnt, sh_cnt_next;
  logic [WIDTH-1:0] sh_val, sh_val_next;
  logic [WIDTH-1:0] result_next;
  logic             result_load;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  function automatic logic [WIDTH-1:0] single_op(input logic [3:0]       ctl,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (ctl)
      ALU_ADD: r = x + y;
      ALU_SUB: r = x - y;
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_SLT: r = ($signed(x) < $signed(y)) ? WIDTH'(1) : '0;
      ALU_LUI: r = y << 16;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign busy   = (state != IDLE);
  assign accept = start && (state == IDLE);

  mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Next-state, shifter step and result selection
  always_comb begin
    state_next  = state;
    sh_cnt_next = sh_cnt;
    sh_val_next = sh_val;
    result_load = 1'b0;
    result_next = result;
    mul_start   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (alucontrol == ALU_SLL) begin
            if (shamt == 5'd0) begin
              result_load = 1'b1;
              result_next = b;
            end else begin
              state_next  = SHIFT;
              sh_cnt_next = shamt;
              sh_val_next = b;
            end
          end else if (alucontrol == ALU_MUL) begin
            state_next = MUL;
            mul_start  = 1'b1;
          end else begin
            result_load = 1'b1;
            result_next = single_op(alucontrol, a, b);
          end
        end
      end
      SHIFT: begin
        sh_val_next = sh_val << 1;
        sh_cnt_next = sh_cnt - 5'd1;
        if (sh_cnt == 5'd1) begin
          result_load = 1'b1;
          result_next = sh_val << 1;
          state_next  = IDLE;
        end
      end
      MUL: begin
        if (mul_done) begin
          result_load = 1'b1;
          result_next = mul_product;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, shifter and result registers; reset aborts any op in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sh_cnt <= '0;
      sh_val <= '0;
      result <= '0;
      zero   <= 1'b1;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      sh_cnt <= sh_cnt_next;
      sh_val <= sh_val_next;
      done   <= result_load;
      if (result_load) begin
        result <= result_next;
        zero   <= (result_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: a behavioural latency/value model checked
// every cycle, plus directed vectors with hand-computed literal results.
module tb_alu_mc;

  localparam int W = 32;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SLL = 4'b0100;
  localparam logic [3:0] C_MUL = 4'b0110;
  localparam logic [3:0] C_SUB = 4'b1010;
  localparam logic [3:0] C_SLT = 4'b1011;
  localparam logic [3:0] C_LUI = 4'b1101;
  localparam logic [3:0] C_BAD = 4'b0111;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   alucontrol = 4'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [4:0]   shamt = 5'd0;
  logic [W-1:0] result;
  logic         zero, busy, done;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic [W-1:0] m_result = '0;
  logic [W-1:0] m_pend = '0;
  logic         m_zero = 1'b1;
  logic         m_done = 1'b0;
  int           m_rem = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .shamt      (shamt),
    .result     (result),
    .zero       (zero),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [W-1:0] act,
                              input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Value and latency (cycles from start to done) of one operation
  task automatic model_op(input logic [3:0] c, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [4:0] s,
                          output logic [W-1:0] v, output int lat);
    lat = 1;
    case (c)
      C_ADD: v = x + y;
      C_SUB: v = x - y;
      C_AND: v = x & y;
      C_OR:  v = x | y;
      C_SLT: v = ($signed(x) < $signed(y)) ? 1 : 0;
      C_LUI: v = {y[15:0], 16'h0000};
      C_SLL: begin v = y << s; lat = int'(s) + 1; end
      C_MUL: begin v = x * y; lat = W + 1; end
      default: v = '0;
    endcase
  endtask

  // Model advance on each edge, then compare all outputs just after it
  always @(posedge clk) begin : model
    logic [W-1:0] v;
    int lat;
    if (reset) begin
      m_result = '0;
      m_zero   = 1'b1;
      m_done   = 1'b0;
      m_rem    = 0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_result = m_pend;
          m_zero   = (m_pend == '0);
          m_done   = 1'b1;
        end
      end else if (start) begin
        model_op(alucontrol, a, b, shamt, v, lat);
        if (lat == 1) begin
          m_result = v;
          m_zero   = (v == '0);
          m_done   = 1'b1;
        end else begin
          m_pend = v;
          m_rem  = lat - 1;
        end
      end
    end
    #1;
    chk("cyc_done", W'(done), W'(m_done));
    chk("cyc_busy", W'(busy), W'(m_rem > 0));
    chk("cyc_result", result, m_result);
    chk("cyc_zero", W'(zero), W'(m_zero));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic go(input logic [3:0] c, input logic [W-1:0] x,
                    input logic [W-1:0] y, input logic [4:0] s);
    alucontrol = c;
    a          = x;
    b          = y;
    shamt      = s;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns the cycle index (1 = first cycle after the accepting edge) of done
  task automatic wait_done(input int max, output int n);
    n = 1;
    while (done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int done_cnt;

    reset = 1'b1;
    tick();
    tick();
    chk("rst_result", result, 32'h0);
    chk("rst_zero", W'(zero), 32'd1);
    chk("rst_busy", W'(busy), 32'd0);
    chk("rst_done", W'(done), 32'd0);
    reset = 1'b0;
    tick();

    go(C_ADD, 32'd5, 32'd7, 5'd0);
    chk("add_result", result, 32'd12);
    chk("add_done", W'(done), 32'd1);
    chk("add_zero", W'(zero), 32'd0);

    alucontrol = C_SUB; a = 32'h1234; b = 32'h1234; start = 1'b1;
    tick();
    chk("sub_result", result, 32'h0);
    chk("sub_zero", W'(zero), 32'd1);
    alucontrol = C_SLT; a = 32'hFFFF_FFFF; b = 32'd1;
    tick();
    start = 1'b0;
    chk("slt_result", result, 32'd1);

    go(C_AND, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
    chk("and_result", result, 32'h0000_F000);
    go(C_OR, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
    chk("or_result", result, 32'h0000_FFF0);
    go(C_SLT, 32'd3, 32'hFFFF_FFFE, 5'd0);
    chk("slt_neg", result, 32'd0);
    go(C_SUB, 32'd0, 32'd1, 5'd0);
    chk("sub_wrap", result, 32'hFFFF_FFFF);
    go(C_BAD, 32'd5, 32'd5, 5'd0);
    chk("bad_result", result, 32'h0);
    chk("bad_zero", W'(zero), 32'd1);

    // sll by 31 with an ignored start mid-shift and operands changed
    go(C_SLL, 32'h0, 32'd1, 5'd31);
    a = '1; b = 32'h5; shamt = 5'd2;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      if (n == 5) begin
        alucontrol = C_ADD;
        start      = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    chk("sll31_lat", 32'(n), 32'd32);
    chk("sll31_result", result, 32'h8000_0000);

    go(C_SLL, 32'h0, 32'h55, 5'd0);
    chk("sll0_done", W'(done), 32'd1);
    chk("sll0_result", result, 32'h55);
    go(C_SLL, 32'h0, 32'h11, 5'd3);
    wait_done(40, n);
    chk("sll3_lat", 32'(n), 32'd4);
    chk("sll3_result", result, 32'h88);

    // mul, then a second mul accepted in the done cycle
    go(C_MUL, 32'h0000_FFFF, 32'h0001_0001, 5'd0);
    wait_done(40, n);
    chk("mul_lat", 32'(n), 32'd33);
    chk("mul_result", result, 32'hFFFF_FFFF);
    go(C_MUL, 32'd3, 32'd5, 5'd0);
    wait_done(40, n);
    chk("mul2_lat", 32'(n), 32'd33);
    chk("mul2_result", result, 32'd15);
    go(C_MUL, 32'h8000_0001, 32'd3, 5'd0);
    wait_done(40, n);
    chk("mul3_result", result, 32'h8000_0003);

    // lui back-to-back
    alucontrol = C_LUI; a = '0; b = 32'h0000_ABCD; start = 1'b1;
    tick();
    chk("lui1_done", W'(done), 32'd1);
    chk("lui1_result", result, 32'hABCD_0000);
    b = 32'h0000_0001;
    tick();
    start = 1'b0;
    chk("lui2_done", W'(done), 32'd1);
    chk("lui2_result", result, 32'h0001_0000);
    tick();
    chk("lui_idle_done", W'(done), 32'd0);

    // reset in cycle 10 of a mul
    go(C_MUL, 32'h0000_FFFF, 32'h0001_0001, 5'd0);
    for (int i = 1; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", W'(busy), 32'd0);
    chk("abort_done", W'(done), 32'd0);
    chk("abort_result", result, 32'h0);
    chk("abort_zero", W'(zero), 32'd1);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    // reset wins over a simultaneous start
    go(C_ADD, 32'd1, 32'd2, 5'd0);
    chk("pre_rst_result", result, 32'd3);
    reset = 1'b1; alucontrol = C_ADD; a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("rst_prio_result", result, 32'h0);
    chk("rst_prio_done", W'(done), 32'd0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-005 SHALL have port alucontrol  input  4  operation code from ALU decoder.
REQ-006 SHALL have port a  input  WIDTH  operand A (rs).
REQ-007 SHALL have port b  input  WIDTH  operand B (rt/immediate).
REQ-008 SHALL have port shamt  input  5  shift amount for sll.
REQ-009 SHALL have port result  output  WIDTH  registered result; holds until next done.
REQ-010 SHALL have port zero  output  1  registered (result==0), updated with result.
REQ-011 SHALL have port busy  output  1  high while a multi-cycle op is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse in the cycle result becomes valid.

Function
REQ-013 SHALL capture alucontrol, a, b, shamt on the edge where start=1 and busy=0; later input changes SHALL NOT affect the op.
REQ-014 SHALL ignore start while busy=1 (no capture, no queueing).
REQ-015 SHALL implement single-cycle codes: 0010 add, 1010 sub, 0000 and, 0001 or, 1011 signed slt (1/0), 1101 lui ({b[15:0],16'b0}); done one cycle after start, busy stays 0.
REQ-016 SHALL implement 0100 sll (b << shamt) iteratively, one bit per cycle; done shamt+1 cycles after start; shamt=0 behaves as single-cycle.
REQ-017 SHALL implement 0110 mul (low WIDTH bits of a*b, unsigned shift-add, one multiplier bit per cycle); done exactly WIDTH+1 cycles after start.
REQ-018 SHALL treat any other code as single-cycle with result=0, zero=1.
REQ-019 SHALL use FSM states IDLE, SHIFT, MUL: IDLE->SHIFT on accepted sll with shamt>0; IDLE->MUL on accepted mul; SHIFT/MUL->IDLE when iteration count expires; otherwise stay.
REQ-020 SHALL assert busy in SHIFT and MUL and deassert it in the done cycle.
REQ-021 SHALL accept a new start in the same cycle done is asserted (back-to-back, no bubble).
REQ-022 SHALL perform add/sub modulo 2^WIDTH with no overflow flag or trap.
REQ-023 SHALL keep result/zero unchanged in every cycle without done.

Reset
REQ-024 SHALL on reset=1 force state IDLE, result=0, zero=1, busy=0, done=0, counters 0, with priority over start.
REQ-025 SHALL abort an in-progress op on reset; no done pulse for the aborted op.

Structure
REQ-026 SHALL place alucontrol code constants and FSM state encodings in shared package alu_pkg, also used by the ALU decoder.
REQ-027 SHALL place the iterative shift-add multiplier in sub-module mul_seq (start/done handshake); shifter and single-cycle ops stay in alu_mc.

Verification
REQ-028 add: a=5, b=7, ctl=0010 -> cycle+1 done=1, result=12, zero=0, busy never 1.
REQ-029 sub/slt: a=b=0x1234, ctl=1010 -> result=0, zero=1; then a=0xFFFFFFFF, b=1, ctl=1011 -> result=1.
REQ-030 sll: b=1, shamt=31, ctl=0100 -> busy cycles 1..31, done at cycle 32, result=0x80000000; start at cycle 5 ignored.
REQ-031 mul: a=0x0000FFFF, b=0x00010001, ctl=0110 -> done at cycle 33, result=0xFFFFFFFF; next op started in done cycle completes normally.
REQ-032 lui back-to-back: b=0x0000ABCD, ctl=1101, start in two consecutive cycles with b changed to 0x00000001 -> results 0xABCD0000 then 0x00010000, done high both cycles.
REQ-033 reset mid-mul at cycle 10 -> next cycle busy=0, done=0, result=0, zero=1; no done pulse afterwards.
